// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - producer and uarttx signal bundle for uart_tx_scheduler
interface uart_tx_scheduler_if #(
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] din;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [IW-1:0]     grant_id;
    logic              utx_newd;
    logic [7:0]        utx_data;
    logic              utx_donetx;

    modport master (
        output req, din, utx_donetx,
        input  ack, done, busy, grant_id, utx_newd, utx_data
    );

    modport slave (
        input  req, din, utx_donetx,
        output ack, done, busy, grant_id, utx_newd, utx_data
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin byte scheduler for a shared uarttx; optional abort timer via UART_TX_SCHED_TIMEOUT_EN
module uart_tx_scheduler #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_scheduler_if.slave  bus
`ifdef UART_TX_SCHED_TIMEOUT_EN
    ,
    output logic                timeout
`endif
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic            donetx_q;
    logic [NREQ-1:0] ack_r;
    logic [NREQ-1:0] done_r;
    logic            busy_r;
    logic [IW-1:0]   grant_r;
    logic            newd_r;
    logic [7:0]      data_r;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int            TW         = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer;
    logic          timeout_r;
    assign timeout = timeout_r;
`endif

    logic          tx_end;
    logic [7:0]    din_b [NREQ];
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;

    // Only a fresh rising edge of donetx ends a byte; a level left over
    // from the previous byte must not complete the current one.
    assign tx_end = bus.utx_donetx & ~donetx_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_din
        assign din_b[g] = bus.din[8*g +: 8];
    end

    // Round-robin pick: first requester after rr_ptr, wrapping; the
    // descending scan lets the nearest candidate overwrite farther ones.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IW'((int'(rr_ptr) + off) % NREQ);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= IW'(NREQ - 1);
            donetx_q  <= 1'b0;
            ack_r     <= '0;
            done_r    <= '0;
            busy_r    <= 1'b0;
            grant_r   <= '0;
            newd_r    <= 1'b0;
            data_r    <= 8'h00;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            timer     <= '0;
            timeout_r <= 1'b0;
`endif
        end else begin
            donetx_q <= bus.utx_donetx;
            ack_r    <= '0;
            done_r   <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        ack_r   <= NREQ'(1) << pick_idx;
                        data_r  <= din_b[pick_idx];
                        grant_r <= pick_idx;
                        rr_ptr  <= pick_idx;
                        busy_r  <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    newd_r <= 1'b1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    timer  <= '0;
`endif
                    state  <= WAIT;
                end
                WAIT: begin
                    if (tx_end) begin
                        newd_r <= 1'b0;
                        done_r <= NREQ'(1) << grant_r;
                        busy_r <= 1'b0;
                        state  <= GAP;
                    end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    else if (timer == TIMER_LAST) begin
                        newd_r    <= 1'b0;
                        timeout_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state     <= GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                GAP: begin
                    // Keeps newd low for a full cycle so uarttx cannot
                    // restart on a stale request.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack      = ack_r;
    assign bus.done     = done_r;
    assign bus.busy     = busy_r;
    assign bus.grant_id = grant_r;
    assign bus.utx_newd = newd_r;
    assign bus.utx_data = data_r;
endmodule
